// File: rtl/issue_pkg.sv
// issue_pkg: types and defaults shared by the ALU issue controller and its scoreboard.
package issue_pkg;

  localparam int NUM_GPR_DEFAULT = 16;
  localparam int OPCODE_W        = 10;

  // Opcode as carried from the instruction decoder to the ALU.
  typedef logic [OPCODE_W-1:0] opcode_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    STALL_RAW = 3'd2,
    STALL_MEM = 3'd3,
    FLUSH     = 3'd4
  } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl_scoreboard.sv
// gpr_scoreboard: one busy bit per GPR. A register is marked busy when an
// instruction writing it issues and cleared when its writeback retires.
// A set and a clear of the same index in one cycle leaves the bit set, since
// the newly issued write is younger than the one retiring.
module gpr_scoreboard
  import issue_pkg::*;
#(
  parameter int NUM_GPR = NUM_GPR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       set_en,
  input  logic [$clog2(NUM_GPR)-1:0] set_idx,
  input  logic                       clr_en,
  input  logic [$clog2(NUM_GPR)-1:0] clr_idx,
  output logic [NUM_GPR-1:0]         busy
);

  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] busy_d;
  logic [NUM_GPR-1:0] set_mask;
  logic [NUM_GPR-1:0] clr_mask;

  // One-hot set/clear masks, clear applied first so set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-entry issue controller between decode and the ALU.
// Holds one instruction, stalls it on register hazards (via gpr_scoreboard)
// or a blocked memory stage, and inserts FLUSH_CYCLES bubbles after a branch.
// Build macro ALU_ISSUE_PERF_EN adds 32-bit issue / stall-cycle counters.
//
// state     | meaning
// IDLE      | holding register empty, decode may present
// ISSUE     | instruction held, issues this cycle unless a hazard exists
// STALL_RAW | held instruction waits for its registers to retire
// STALL_MEM | held instruction waits for the memory stage to unblock
// FLUSH     | branch bubbles, decode blocked, flush asserted
module alu_issue_ctrl
  import issue_pkg::*;
#(
  parameter int NUM_GPR      = NUM_GPR_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  output logic                       dec_ready,
  input  logic [OPCODE_W-1:0]        dec_opcode,
  input  logic [$clog2(NUM_GPR)-1:0] dec_src1,
  input  logic [$clog2(NUM_GPR)-1:0] dec_src2,
  input  logic [$clog2(NUM_GPR)-1:0] dec_dst,
  input  logic                       dec_dst_we,
  output logic                       alu_enable,
  output logic [OPCODE_W-1:0]        alu_opcode,
  input  logic                       mem_blocked,
  input  logic                       wb_valid,
  input  logic [$clog2(NUM_GPR)-1:0] wb_dst,
  input  logic                       branch,
  output logic                       flush
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]                perf_issued,
  output logic [31:0]                perf_stall_cycles
`endif
);

  localparam int IDX_W = $clog2(NUM_GPR);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  issue_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  opcode_t          held_op_q;
  logic [IDX_W-1:0] held_src1_q, held_src2_q, held_dst_q;
  logic             held_we_q;

  logic [NUM_GPR-1:0] busy;
  logic [NUM_GPR-1:0] busy_eff;
  logic               raw_hit;
  logic               issue;
  logic               accept;

  gpr_scoreboard #(.NUM_GPR(NUM_GPR)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue && held_we_q),
    .set_idx (held_dst_q),
    .clr_en  (wb_valid),
    .clr_idx (wb_dst),
    .busy    (busy)
  );

  // A writeback retiring this cycle already frees its register, so a waiting
  // instruction can issue on the very next cycle.
  always_comb begin
    busy_eff = busy;
    if (wb_valid) busy_eff[wb_dst] = 1'b0;
    raw_hit = busy_eff[held_src1_q] | busy_eff[held_src2_q] |
              (held_we_q & busy_eff[held_dst_q]);
  end

  // Next-state and outputs; hazard priority is branch, then memory, then RAW.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    dec_ready  = 1'b0;
    flush      = 1'b0;
    alu_enable = 1'b0;
    alu_opcode = '0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          dec_ready = !branch;
          if (branch) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else if (dec_valid) begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (branch) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else if (mem_blocked) begin
            state_d = STALL_MEM;
          end else if (raw_hit) begin
            state_d = STALL_RAW;
          end else begin
            issue      = 1'b1;
            alu_enable = 1'b1;
            alu_opcode = held_op_q;
            dec_ready  = 1'b1;
            state_d    = dec_valid ? ISSUE : IDLE;
          end
        end
        STALL_RAW: begin
          if (branch) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else if (!raw_hit) begin
            state_d = ISSUE;
          end
        end
        STALL_MEM: begin
          if (branch) begin
            state_d = FLUSH;
            cnt_d   = CNT_LOAD;
          end else if (!mem_blocked) begin
            state_d = ISSUE;
          end
        end
        FLUSH: begin
          flush = 1'b1;
          if (branch) begin
            cnt_d = CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign accept = dec_valid && dec_ready;

  // State, bubble counter and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      held_op_q   <= '0;
      held_src1_q <= '0;
      held_src2_q <= '0;
      held_dst_q  <= '0;
      held_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        held_op_q   <= dec_opcode;
        held_src1_q <= dec_src1;
        held_src2_q <= dec_src2;
        held_dst_q  <= dec_dst;
        held_we_q   <= dec_dst_we;
      end
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_stall_q;

  // Free-running wrap-around counters of issues and stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue) perf_issued_q <= perf_issued_q + 32'd1;
      if (state_q == STALL_RAW || state_q == STALL_MEM)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued       = perf_issued_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed timing checks plus a randomized phase. Accepted
// instructions are queued in order; a negedge monitor pops one on every ALU
// enable and checks opcode order, register-hazard freedom against a busy-set
// model, hazard priority and the post-branch flush window.
// Define ALU_ISSUE_PERF_EN to also exercise the performance counters.
module tb_alu_issue_ctrl;

  localparam int NG = 16;
  localparam int FC = 2;

  typedef struct {
    logic [9:0] op;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] d;
    logic       we;
  } instr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic       dec_ready;
  logic [9:0] dec_opcode;
  logic [3:0] dec_src1, dec_src2, dec_dst;
  logic       dec_dst_we;
  logic       alu_enable;
  logic [9:0] alu_opcode;
  logic       mem_blocked;
  logic       wb_valid;
  logic [3:0] wb_dst;
  logic       branch;
  logic       flush;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall_cycles;
`endif

  alu_issue_ctrl #(.NUM_GPR(NG), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_opcode  (dec_opcode),
    .dec_src1    (dec_src1),
    .dec_src2    (dec_src2),
    .dec_dst     (dec_dst),
    .dec_dst_we  (dec_dst_we),
    .alu_enable  (alu_enable),
    .alu_opcode  (alu_opcode),
    .mem_blocked (mem_blocked),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .branch      (branch),
    .flush       (flush)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_fail   = 0;
  instr_t   exp_q[$];
  logic [NG-1:0] mbusy = '0;
  logic [NG-1:0] meff;
  int       flush_left = 0;
  instr_t   cur;
  logic     got;
  logic     s_en, s_flush, s_ready;
  logic [9:0] s_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest accepted instruction on each issue.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mbusy      = '0;
      flush_left = 0;
    end else begin
      chk("flush_window", 32'(flush), 32'(flush_left > 0));
      if (flush_left > 0) chk("ready_in_flush", 32'(dec_ready), 32'd0);
      meff = mbusy;
      if (wb_valid) meff[wb_dst] = 1'b0;
      got = 1'b0;
      if (alu_enable) begin
        chk("issue_under_branch_or_mem", {30'd0, branch, mem_blocked}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_issue actual_op=0x%0h expected=none t=%0t", alu_opcode, $time);
        end else begin
          cur = exp_q.pop_front();
          got = 1'b1;
          chk("issue_opcode", 32'(alu_opcode), 32'(cur.op));
          chk("issue_hazard_free",
              32'(meff[cur.s1] | meff[cur.s2] | (cur.we & meff[cur.d])), 32'd0);
        end
      end
      mbusy = meff;
      if (got && cur.we) mbusy[cur.d] = 1'b1;
      if (branch) begin
        exp_q.delete();
        flush_left = FC;
      end else if (flush_left > 0) begin
        flush_left--;
      end
    end
  end

  task automatic drive(input logic v, input logic [9:0] op, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] d, input logic we);
    dec_valid  = v;
    dec_opcode = op;
    dec_src1   = s1;
    dec_src2   = s2;
    dec_dst    = d;
    dec_dst_we = we;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 10'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    mem_blocked = 1'b0;
    wb_valid    = 1'b0;
    wb_dst      = 4'd0;
    branch      = 1'b0;
  endtask

  // Advance one cycle: sample outputs at negedge, record an accept, move to posedge+1.
  task automatic tick();
    instr_t e;
    @(negedge clk);
    s_en    = alu_enable;
    s_op    = alu_opcode;
    s_flush = flush;
    s_ready = dec_ready;
    #1;
    if (!reset && dec_valid && dec_ready) begin
      e.op = dec_opcode; e.s1 = dec_src1; e.s2 = dec_src2; e.d = dec_dst; e.we = dec_dst_we;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    chk("reset_ready", 32'(s_ready), 32'd0);
    chk("reset_enable", 32'(s_en), 32'd0);
    chk("reset_flush", 32'(s_flush), 32'd0);
    chk("reset_opcode", 32'(s_op), 32'd0);
    tick();
    reset = 1'b0;

    // First issue lands the cycle after accept.
    drive(1'b1, 10'h001, 4'd0, 4'd0, 4'd3, 1'b1);
    tick();
    chk("first_accept_ready", 32'(s_ready), 32'd1);
    chk("first_no_same_cycle_issue", 32'(s_en), 32'd0);
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    chk("first_issue_en", 32'(s_en), 32'd1);
    chk("first_issue_op", 32'(s_op), 32'h001);

    // Read of r3 stalls until r3 retires, then issues the cycle after.
    drive(1'b1, 10'h002, 4'd3, 4'd0, 4'd4, 1'b0);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    chk("raw_stall_a", 32'(s_en), 32'd0);
    tick();
    chk("raw_stall_b", 32'(s_en), 32'd0);
    wb_valid = 1'b1; wb_dst = 4'd3;
    tick();
    chk("raw_wb_cycle", 32'(s_en), 32'd0);
    wb_valid = 1'b0;
    tick();
    chk("raw_release_en", 32'(s_en), 32'd1);
    chk("raw_release_op", 32'(s_op), 32'h002);

    // Memory stall for 4 cycles, issue one cycle after it drops.
    drive(1'b1, 10'h003, 4'd0, 4'd0, 4'd1, 1'b0);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    mem_blocked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mem_stall_en", 32'(s_en), 32'd0);
    end
    mem_blocked = 1'b0;
    tick();
    chk("mem_drop_cycle", 32'(s_en), 32'd0);
    tick();
    chk("mem_release_en", 32'(s_en), 32'd1);
    chk("mem_release_op", 32'(s_op), 32'h003);

    // Branch kills the held instruction; decode blocked during the bubbles.
    drive(1'b1, 10'h004, 4'd0, 4'd0, 4'd6, 1'b1);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    branch = 1'b1;
    tick();
    chk("branch_cycle_en", 32'(s_en), 32'd0);
    chk("branch_cycle_flush", 32'(s_flush), 32'd0);
    branch = 1'b0;
    drive(1'b1, 10'h0ff, 4'd0, 4'd0, 4'd7, 1'b0);
    for (int i = 0; i < FC; i++) begin
      tick();
      chk("flush_active", 32'(s_flush), 32'd1);
      chk("flush_ready_low", 32'(s_ready), 32'd0);
      chk("flush_no_issue", 32'(s_en), 32'd0);
    end
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    chk("flush_done", 32'(s_flush), 32'd0);
    chk("flush_done_ready", 32'(s_ready), 32'd1);

    // Branch inside the flush window restarts the count.
    branch = 1'b1;
    tick();
    branch = 1'b0;
    tick();
    chk("restart_f1", 32'(s_flush), 32'd1);
    branch = 1'b1;
    tick();
    chk("restart_f2", 32'(s_flush), 32'd1);
    branch = 1'b0;
    tick();
    chk("restart_f3", 32'(s_flush), 32'd1);
    tick();
    chk("restart_f4", 32'(s_flush), 32'd1);
    tick();
    chk("restart_end", 32'(s_flush), 32'd0);

    // Same-cycle writeback of r5 and issue writing r5 leaves r5 busy.
    drive(1'b1, 10'h005, 4'd0, 4'd0, 4'd5, 1'b1);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    wb_valid = 1'b1; wb_dst = 4'd5;
    tick();
    chk("setwin_issue", 32'(s_en), 32'd1);
    wb_valid = 1'b0;
    drive(1'b1, 10'h006, 4'd5, 4'd0, 4'd2, 1'b0);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    chk("setwin_busy_a", 32'(s_en), 32'd0);
    tick();
    chk("setwin_busy_b", 32'(s_en), 32'd0);
    wb_valid = 1'b1; wb_dst = 4'd5;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("setwin_release", 32'(s_en), 32'd1);
    chk("setwin_release_op", 32'(s_op), 32'h006);

    // Ten independent back-to-back ops issue one per cycle.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      if (i < 10) drive(1'b1, 10'(16 + i), 4'd0, 4'd0, 4'(6 + i), 1'b1);
      else        drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
      tick();
      if (i == 0) chk("b2b_first_idle", 32'(s_en), 32'd0);
      else begin
        chk("b2b_en", 32'(s_en), 32'd1);
        chk("b2b_op", 32'(s_op), 32'(16 + i - 1));
      end
      if (i < 10) chk("b2b_ready", 32'(s_ready), 32'd1);
    end
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_issued", perf_issued, 32'd10);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd0);
`endif

    // Reset during a RAW stall abandons the held instruction.
    drive(1'b1, 10'h0aa, 4'd6, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 10'h000, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    tick();
    chk("stall_before_reset", 32'(s_en), 32'd0);
    reset = 1'b1;
    tick();
    chk("midreset_en", 32'(s_en), 32'd0);
    chk("midreset_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_reset_ready", 32'(s_ready), 32'd1);
    tick();
    chk("post_reset_no_issue", 32'(s_en), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      int pick;
      drive(($urandom_range(0, 9) < 6), 10'($urandom_range(1, 1023)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      mem_blocked = ($urandom_range(0, 9) < 2);
      branch      = ($urandom_range(0, 99) < 3);
      wb_valid    = 1'b0;
      if ($urandom_range(0, 9) < 3) begin
        pick = $urandom_range(0, 15);
        for (int k = 0; k < 4; k++) begin
          if (!mbusy[pick]) pick = $urandom_range(0, 15);
        end
        wb_valid = 1'b1;
        wb_dst   = 4'(pick);
      end
      tick();
    end

    // Drain: retire every register and let the last held instruction issue.
    idle_inputs();
    for (int i = 0; i < NG; i++) begin
      wb_valid = 1'b1;
      wb_dst   = 4'(i);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
